// File: rtl/ets_frame_streamer.sv
// Reads one complete frame from the ETS triple-buffer read port and streams it
// out on a valid/ready interface, releasing the buffer with r_finish when done.
module ets_frame_streamer #(
  parameter int FRAME_LEN = 2240,
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int HOLDOFF   = 4
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          en,
  input  logic          r_valid,
  output logic [AW-1:0] raddr,
  output logic          r_occur,
  input  logic [DW-1:0] rdata,
  output logic          r_finish,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic          busy,
  output logic [15:0]   frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_FINISH,
    S_HOLD
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);
  localparam int            HW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLDOFF > 1) ? HOLDOFF - 1 : 0);

  state_t        state;
  logic [AW-1:0] addr;
  logic [HW-1:0] hold_cnt;

  // Read pipeline: one RAM cycle in flight, then a 2-entry skid FIFO.
  logic          inflight;
  logic          inflight_last;
  logic [DW-1:0] fifo_data [2];
  logic          fifo_last [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    fifo_count;

  logic issue;
  logic push;
  logic pop;

  // Credit check uses only registered state, so m_tready never reaches r_occur;
  // two credits cover the FIFO plus the word still coming out of the RAM.
  assign issue    = (state == S_READ) && ((fifo_count + {1'b0, inflight}) < 2'd2);
  assign push     = inflight;
  assign pop      = m_tvalid && m_tready;

  assign r_occur  = issue;
  assign raddr    = addr;
  assign m_tvalid = (fifo_count != 2'd0);
  assign m_tdata  = fifo_data[rd_ptr];
  assign m_tlast  = m_tvalid && fifo_last[rd_ptr];

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register sees the pre-edge value of every other register.
  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      hold_cnt  <= '0;
      r_finish  <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      r_finish <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (en && r_valid) begin
            state <= S_READ;
            addr  <= '0;
            busy  <= 1'b1;
          end
        end
        S_READ: begin
          if (issue) begin
            addr <= addr + 1'b1;
            if (addr == LAST_ADDR) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && m_tlast) begin
            state     <= S_FINISH;
            r_finish  <= 1'b1;
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        S_FINISH: begin
          // The FINISH cycle is the first of the HOLDOFF cycles, so r_valid is
          // next sampled exactly HOLDOFF cycles after the r_finish pulse.
          addr     <= '0;
          hold_cnt <= HW'(1);
          if (HOLDOFF <= 1) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the two FIFO data entries are reset as well, because m_tdata is
  // driven straight from the head entry and must read 0 coming out of reset.
  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      fifo_count    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      inflight      <= issue;
      inflight_last <= (addr == LAST_ADDR);
      if (push) begin
        fifo_data[wr_ptr] <= rdata;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule
